// File: rtl/rca_lsq_arbiter_if.sv
// OU-side and LSQ-side signal bundle for the RCA load/store arbiter.
// slave: arbiter view; master: OU slots plus LSQ as seen from outside.
interface rca_lsq_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      slot_enable;
  logic [NUM_REQ*XLEN-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ*3-1:0]    req_fn3;
  logic [NUM_REQ-1:0]      req_load;
  logic [NUM_REQ-1:0]      req_store;
  logic [NUM_REQ-1:0]      req_new_request;
  logic [NUM_REQ-1:0]      req_lsq_full;
  logic [XLEN-1:0]         req_load_data;
  logic [NUM_REQ-1:0]      req_load_complete;
  logic [XLEN-1:0]         lsq_addr;
  logic [XLEN-1:0]         lsq_data;
  logic [2:0]              lsq_fn3;
  logic                    lsq_load;
  logic                    lsq_store;
  logic                    lsq_new_request;
  logic                    lsq_full;
  logic [XLEN-1:0]         lsq_load_data;
  logic                    lsq_load_complete;
  logic                    resp_error;

  modport slave (
    input  slot_enable, req_addr, req_data, req_fn3, req_load, req_store,
           req_new_request, lsq_full, lsq_load_data, lsq_load_complete,
    output req_lsq_full, req_load_data, req_load_complete, lsq_addr, lsq_data,
           lsq_fn3, lsq_load, lsq_store, lsq_new_request, resp_error
  );

  modport master (
    output slot_enable, req_addr, req_data, req_fn3, req_load, req_store,
           req_new_request, lsq_full, lsq_load_data, lsq_load_complete,
    input  req_lsq_full, req_load_data, req_load_complete, lsq_addr, lsq_data,
           lsq_fn3, lsq_load, lsq_store, lsq_new_request, resp_error
  );
endinterface

// File: rtl/rca_lsq_arbiter.sv
// Round-robin token arbiter sharing one LSQ port between NUM_REQ OU slots,
// with an in-order tag FIFO that steers load completions back to the issuer.
module rca_lsq_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int XLEN      = 32,
  parameter int TAG_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  rca_lsq_arbiter_if.slave  bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic [OW-1:0] owner_q, owner_d, owner_nxt;
  logic [OW-1:0] tag_q [TAG_DEPTH];
  logic [TW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [TW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          owner_en, tag_full, tag_empty, stall, issue, push, pop, found;
  logic [OW-1:0] head;

  assign owner_en  = bus.slot_enable[owner_q];
  assign tag_full  = (count_q == (TW+1)'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign stall     = bus.lsq_full | (bus.req_load[owner_q] & tag_full);
  assign issue     = owner_en & bus.req_new_request[owner_q] & ~stall;
  assign push      = issue & bus.req_load[owner_q];
  assign pop       = bus.lsq_load_complete & ~tag_empty;
  assign head      = tag_q[rd_ptr_q];

  assign bus.lsq_addr        = bus.req_addr[int'(owner_q)*XLEN +: XLEN];
  assign bus.lsq_data        = bus.req_data[int'(owner_q)*XLEN +: XLEN];
  assign bus.lsq_fn3         = bus.req_fn3[int'(owner_q)*3 +: 3];
  assign bus.lsq_load        = bus.req_load[owner_q];
  assign bus.lsq_store       = bus.req_store[owner_q];
  assign bus.lsq_new_request = issue;
  assign bus.req_load_data   = bus.lsq_load_data;
  assign bus.resp_error      = err_q;

  always_comb begin
    bus.req_lsq_full = '1;
    if (owner_en) bus.req_lsq_full[owner_q] = stall;
    bus.req_load_complete = '0;
    if (pop) bus.req_load_complete[head] = 1'b1;
  end

  // Token moves to the next enabled slot; with none enabled it just walks.
  always_comb begin
    found     = 1'b0;
    owner_nxt = owner_q;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found && bus.slot_enable[(int'(owner_q) + i) % NUM_REQ]) begin
        found     = 1'b1;
        owner_nxt = OW'((int'(owner_q) + i) % NUM_REQ);
      end
    end
    if (!found && !owner_en)
      owner_nxt = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    owner_d = (owner_en && stall) ? owner_q : owner_nxt;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    err_d    = err_q | (bus.lsq_load_complete & tag_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      owner_q  <= owner_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) tag_q[wr_ptr_q] <= owner_q;
    end
  end
endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Directed scoreboard bench: stimulus queues expected issues/completions,
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_rca_lsq_arbiter;
  localparam int NUM_REQ = 4;
  localparam int XLEN    = 32;

  typedef logic [2*XLEN+4:0] iss_t;
  typedef logic [NUM_REQ+XLEN-1:0] cmp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  iss_t exp_iss[$];
  cmp_t exp_cmp[$];
  iss_t e_iss;
  cmp_t e_cmp;

  rca_lsq_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  rca_lsq_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .TAG_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic iss_t iss_of(int s, bit ld);
    logic [XLEN-1:0] a, d;
    logic [2:0]      f;
    a = 32'hA000_0000 + 32'(s);
    d = 32'hD000_0000 + 32'(s);
    f = 3'(s + 1);
    return {a, d, f, ld, ~ld};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.lsq_new_request) begin
        if (exp_iss.size() == 0) check("unexpected_issue", 128'd1, 128'd0);
        else begin
          e_iss = exp_iss.pop_front();
          check("issue", {bus.lsq_addr, bus.lsq_data, bus.lsq_fn3, bus.lsq_load, bus.lsq_store}, e_iss);
        end
      end
      if (bus.req_load_complete != '0) begin
        if (exp_cmp.size() == 0) check("unexpected_strobe", 128'(bus.req_load_complete), 128'd0);
        else begin
          e_cmp = exp_cmp.pop_front();
          check("completion", {bus.req_load_complete, bus.req_load_data}, e_cmp);
        end
      end
    end
  end

  logic [3:0] full_a [10];
  logic [3:0] full_b [5];
  logic [3:0] full_c [6];

  initial begin
    full_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111,
               4'b1111, 4'b1111, 4'b1110, 4'b1101, 4'b1011};
    full_b = '{4'b1111, 4'b1101, 4'b0111, 4'b1101, 4'b0111};
    full_c = '{4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1011};

    bus.slot_enable       = 4'b1111;
    bus.req_load          = '0;
    bus.req_store         = '0;
    bus.req_new_request   = '0;
    bus.lsq_full          = 1'b0;
    bus.lsq_load_data     = '0;
    bus.lsq_load_complete = 1'b0;
    for (int s = 0; s < NUM_REQ; s++) begin
      bus.req_addr[s*XLEN +: XLEN] = 32'hA000_0000 + 32'(s);
      bus.req_data[s*XLEN +: XLEN] = 32'hD000_0000 + 32'(s);
      bus.req_fn3[s*3 +: 3]        = 3'(s + 1);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_lsq_full", 128'(bus.req_lsq_full), 128'(4'b1110));
    check("reset_strobe", 128'(bus.req_load_complete), 128'd0);
    check("reset_error", 128'(bus.resp_error), 128'd0);

    // Continuous loads from all slots; tag FIFO fills, then drains in order.
    for (int k = 0; k < 7; k++) exp_iss.push_back(iss_of(k % 4, 1'b1));
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) begin
        rst = 1'b1;
        bus.req_new_request = 4'b1111;
        bus.req_load        = 4'b1111;
      end
      if (c == 10) bus.req_new_request = '0;
      if (c >= 6 && c <= 12) begin
        bus.lsq_load_complete = 1'b1;
        bus.lsq_load_data     = 32'h1111_0000 + 32'(c);
        exp_cmp.push_back({4'b0001 << ((c - 6) % 4), 32'h1111_0000 + 32'(c)});
      end else begin
        bus.lsq_load_complete = 1'b0;
      end
      @(negedge clk);
      if (c < 10) check($sformatf("a_lsq_full_c%0d", c), 128'(bus.req_lsq_full), 128'(full_a[c]));
    end
    check("a_no_error", 128'(bus.resp_error), 128'd0);

    // Sparse enable: token alternates 1,3 and disabled slots see full.
    step();
    rst = 1'b0;
    bus.slot_enable     = 4'b1010;
    bus.req_new_request = '0;
    bus.req_load        = '0;
    @(negedge clk);
    check("b_reset_full", 128'(bus.req_lsq_full), 128'(4'b1111));
    exp_iss.push_back(iss_of(1, 1'b0));
    exp_iss.push_back(iss_of(3, 1'b0));
    exp_iss.push_back(iss_of(1, 1'b0));
    exp_iss.push_back(iss_of(3, 1'b0));
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        rst = 1'b1;
        bus.req_new_request = 4'b1010;
        bus.req_store       = 4'b1010;
      end
      if (c == 5) bus.req_new_request = '0;
      @(negedge clk);
      if (c < 5) check($sformatf("b_lsq_full_c%0d", c), 128'(bus.req_lsq_full), 128'(full_b[c]));
    end

    // LSQ back-pressure while slot 2 owns the token.
    step();
    rst = 1'b0;
    bus.slot_enable = 4'b1111;
    bus.req_store   = '0;
    @(negedge clk);
    exp_iss.push_back(iss_of(2, 1'b1));
    for (int c = 0; c < 9; c++) begin
      step();
      case (c)
        0: rst = 1'b1;
        2: begin
          bus.lsq_full        = 1'b1;
          bus.req_new_request = 4'b0100;
          bus.req_load        = 4'b0100;
        end
        5: bus.lsq_full = 1'b0;
        6: begin
          bus.req_new_request   = '0;
          bus.lsq_load_complete = 1'b1;
          bus.lsq_load_data     = 32'hCAFE_0002;
          exp_cmp.push_back({4'b0100, 32'hCAFE_0002});
        end
        7: bus.lsq_load_data = 32'hBAD0_0000;
        8: bus.lsq_load_complete = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c < 6) check($sformatf("c_lsq_full_c%0d", c), 128'(bus.req_lsq_full), 128'(full_c[c]));
      if (c == 7) begin
        check("d_empty_no_strobe", 128'(bus.req_load_complete), 128'd0);
        check("d_error_not_yet", 128'(bus.resp_error), 128'd0);
      end
      if (c == 8) check("d_error_set", 128'(bus.resp_error), 128'd1);
    end
    repeat (3) step();
    @(negedge clk);
    check("d_error_sticky", 128'(bus.resp_error), 128'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("d_error_cleared", 128'(bus.resp_error), 128'd0);

    step();
    rst = 1'b1;
    repeat (2) step();
    check("issues_drained", 128'(exp_iss.size()), 128'd0);
    check("completions_drained", 128'(exp_cmp.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
